// File: rtl/simple_cpu_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// simple_cpu_top
// Top level of a 16-bit single-accumulator teaching CPU. Holds the sequencer,
// PC, IR, ACC, MR (high word of a multiply), the ALU and one unified
// program/data memory. Each instruction takes two cycles (FETCH, EXEC). HALT
// parks the core until the continue button is pressed, then execution resumes
// at the instruction after the HALT.
//
// Ports
//   clk_100MHz   : system clock, all state changes on the rising edge
//   rst_n        : asynchronous reset, ACTIVE HIGH despite the legacy name
//   continue_btn : raw pushbutton, asynchronous to the clock, active high
//   alu_flags    : {ZF, CF, OF, NF} from the last flag-updating instruction
//
// Parameters
//   MEM_INIT : memory image name; the memory is always preloaded with the
//              built-in demo program (sum 1..100 followed by ALU steps)
//   DATA_W   : datapath / memory word width
//   ADDR_W   : memory and PC address width
// -----------------------------------------------------------------------------
module simple_cpu_top #(
    parameter string MEM_INIT = "program.hex",
    parameter int    DATA_W   = 16,
    parameter int    ADDR_W   = 8
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       continue_btn,
    output logic [3:0] alu_flags
);
    localparam int OP_W  = DATA_W - ADDR_W;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [OP_W-1:0] OP_STORE  = OP_W'(8'h01);
    localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(8'h02);
    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(8'h03);
    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(8'h04);
    localparam logic [OP_W-1:0] OP_JMPGEZ = OP_W'(8'h05);
    localparam logic [OP_W-1:0] OP_JMP    = OP_W'(8'h06);
    localparam logic [OP_W-1:0] OP_HALT   = OP_W'(8'h07);
    localparam logic [OP_W-1:0] OP_MPY    = OP_W'(8'h08);
    localparam logic [OP_W-1:0] OP_AND    = OP_W'(8'h0A);
    localparam logic [OP_W-1:0] OP_OR     = OP_W'(8'h0B);
    localparam logic [OP_W-1:0] OP_NOT    = OP_W'(8'h0C);
    localparam logic [OP_W-1:0] OP_SHIFTR = OP_W'(8'h0D);
    localparam logic [OP_W-1:0] OP_SHIFTL = OP_W'(8'h0E);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    // Built-in demo program. Loop: SUM += I; I -= 1; repeat while I-1 >= 0.
    // The final "LOAD ZERO; ADD SUM" leaves ACC=5050 with flags from a
    // positive add, so the first HALT shows ZF=0, NF=0.
    function automatic logic [DATA_W-1:0] builtin_word(input int addr);
        logic [15:0] w;
        case (addr)
            8'h00: w = 16'h0220;  // LOAD  C100
            8'h01: w = 16'h0130;  // STORE I
            8'h02: w = 16'h0221;  // LOAD  ZERO
            8'h03: w = 16'h0131;  // STORE SUM
            8'h04: w = 16'h0231;  // loop: LOAD SUM
            8'h05: w = 16'h0330;  // ADD   I
            8'h06: w = 16'h0131;  // STORE SUM
            8'h07: w = 16'h0230;  // LOAD  I
            8'h08: w = 16'h0422;  // SUB   ONE
            8'h09: w = 16'h0130;  // STORE I
            8'h0A: w = 16'h0422;  // SUB   ONE
            8'h0B: w = 16'h0504;  // JMPGEZ loop
            8'h0C: w = 16'h0221;  // LOAD  ZERO
            8'h0D: w = 16'h0331;  // ADD   SUM
            8'h0E: w = 16'h0700;  // HALT
            8'h0F: w = 16'h0D00;  // SHIFTR
            8'h10: w = 16'h0700;  // HALT
            8'h11: w = 16'h0E00;  // SHIFTL
            8'h12: w = 16'h0700;  // HALT
            8'h13: w = 16'h0C00;  // NOT
            8'h14: w = 16'h0700;  // HALT
            8'h15: w = 16'h0420;  // SUB   C100
            8'h16: w = 16'h0700;  // HALT
            8'h17: w = 16'h0823;  // MPY   CM5050
            8'h18: w = 16'h0700;  // HALT
            8'h19: w = 16'h0224;  // LOAD  C32767
            8'h1A: w = 16'h0322;  // ADD   ONE
            8'h1B: w = 16'h0700;  // HALT
            8'h1C: w = 16'h0C00;  // NOT
            8'h1D: w = 16'h0700;  // HALT
            8'h1E: w = 16'h0500;  // JMPGEZ 0
            8'h20: w = 16'd100;   // C100
            8'h21: w = 16'h0000;  // ZERO
            8'h22: w = 16'h0001;  // ONE
            8'h23: w = 16'hEC46;  // CM5050 (-5050)
            8'h24: w = 16'h7FFF;  // C32767
            default: w = 16'h0000;
        endcase
        return DATA_W'(w);
    endfunction

    // ---------------------------------------------------------------- memory
    // Combinational read keeps every instruction at exactly two cycles.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = builtin_word(i);
    end

    // ----------------------------------------------------------------- state
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mr_q, mr_d;
    logic [3:0]        flags_q, flags_d;
    logic              btn_meta_q, btn_sync_q, btn_prev_q;

    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] op_addr;
    logic              continue_pulse;

    assign opcode    = ir_q[DATA_W-1:ADDR_W];
    assign op_addr   = ir_q[ADDR_W-1:0];
    assign mem_addr  = (state_q == S_FETCH) ? pc_q : op_addr;
    assign mem_rdata = mem_q[mem_addr];
    assign alu_flags = flags_q;

    // Two-flop synchroniser plus edge detect: a held button yields one pulse.
    // A button already high at reset release yields its pulse while the core
    // is running, where it is ignored.
    assign continue_pulse = btn_sync_q & ~btn_prev_q;

    always_ff @(posedge clk_100MHz or posedge rst_n) begin
        if (rst_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= continue_btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    // ------------------------------------------------------ FSM: state reg
    always_ff @(posedge clk_100MHz or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            mr_q    <= '0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            mr_q    <= mr_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (mem_we) mem_q[op_addr] <= acc_q;
    end

    // ----------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_EXEC;
            S_EXEC:   state_d = (opcode == OP_HALT) ? S_HALTED : S_FETCH;
            S_HALTED: if (continue_pulse) state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------- ALU arithmetic
    logic [DATA_W:0]     add_full, sub_full;
    logic [2*DATA_W-1:0] acc_ext, opd_ext, prod;
    logic                add_of, sub_of, mpy_of;

    always_comb begin
        add_full = {1'b0, acc_q} + {1'b0, mem_rdata};
        sub_full = {1'b0, acc_q} - {1'b0, mem_rdata};
        add_of   = (acc_q[DATA_W-1] == mem_rdata[DATA_W-1]) &&
                   (add_full[DATA_W-1] != acc_q[DATA_W-1]);
        sub_of   = (acc_q[DATA_W-1] != mem_rdata[DATA_W-1]) &&
                   (sub_full[DATA_W-1] != acc_q[DATA_W-1]);
        // Low 2*DATA_W bits of the product of sign-extended operands equal the
        // signed product.
        acc_ext  = {{DATA_W{acc_q[DATA_W-1]}}, acc_q};
        opd_ext  = {{DATA_W{mem_rdata[DATA_W-1]}}, mem_rdata};
        prod     = acc_ext * opd_ext;
        // Representable in DATA_W signed iff the top DATA_W+1 bits agree.
        mpy_of   = ~((&prod[2*DATA_W-1:DATA_W-1]) | ~(|prod[2*DATA_W-1:DATA_W-1]));
    end

    // ------------------------------------------------- FSM: output/datapath
    logic [DATA_W-1:0] alu_res;
    logic              alu_cf, alu_of, flag_upd;

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        mr_d     = mr_q;
        flags_d  = flags_q;
        mem_we   = 1'b0;
        alu_res  = acc_q;
        alu_cf   = 1'b0;
        alu_of   = 1'b0;
        flag_upd = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d = mem_rdata;
                pc_d = pc_q + 1'b1;
            end
            S_EXEC: begin
                case (opcode)
                    OP_STORE:  mem_we = 1'b1;
                    OP_LOAD:   acc_d  = mem_rdata;
                    OP_ADD: begin
                        alu_res = add_full[DATA_W-1:0]; alu_cf = add_full[DATA_W];
                        alu_of = add_of; flag_upd = 1'b1;
                    end
                    OP_SUB: begin
                        alu_res = sub_full[DATA_W-1:0]; alu_cf = sub_full[DATA_W];
                        alu_of = sub_of; flag_upd = 1'b1;
                    end
                    OP_JMPGEZ: if (!acc_q[DATA_W-1]) pc_d = op_addr;
                    OP_JMP:    pc_d = op_addr;
                    OP_MPY: begin
                        alu_res = prod[DATA_W-1:0]; mr_d = prod[2*DATA_W-1:DATA_W];
                        alu_of = mpy_of; flag_upd = 1'b1;
                    end
                    OP_AND: begin alu_res = acc_q & mem_rdata; flag_upd = 1'b1; end
                    OP_OR:  begin alu_res = acc_q | mem_rdata; flag_upd = 1'b1; end
                    OP_NOT: begin alu_res = ~acc_q; flag_upd = 1'b1; end
                    OP_SHIFTR: begin
                        alu_res = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
                        alu_cf = acc_q[0]; flag_upd = 1'b1;
                    end
                    OP_SHIFTL: begin
                        alu_res = {acc_q[DATA_W-2:0], 1'b0};
                        alu_cf = acc_q[DATA_W-1]; flag_upd = 1'b1;
                    end
                    default: ;  // HALT and undefined opcodes change no datapath state
                endcase
                if (flag_upd) begin
                    acc_d   = alu_res;
                    flags_d = {(alu_res == '0), alu_cf, alu_of, alu_res[DATA_W-1]};
                end
            end
            default: ;  // HALTED holds everything
        endcase
    end

endmodule

// File: tb/tb_simple_cpu_top.sv
`timescale 1ns/1ps
module tb_simple_cpu_top;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] flags;

    simple_cpu_top #(.MEM_INIT(""), .DATA_W(16), .ADDR_W(8)) dut (
        .clk_100MHz  (clk),
        .rst_n       (rst),
        .continue_btn(btn),
        .alu_flags   (flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [15:0] acc;
        logic [15:0] mr;
        logic [3:0]  flags;   // {ZF, CF, OF, NF}
        logic [7:0]  pc;      // PC while halted (address after the HALT)
    } step_t;

    step_t steps[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_halted(input string name, input int budget);
        int k = 0;
        while (dut.state_q !== 2'd2 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, " halted"}, 32'(dut.state_q), 32'd2);
    endtask

    task automatic press_hold(input int n);
        btn = 1'b1;
        cycles(n);
        btn = 1'b0;
        cycles(5);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " flags"}, 32'(flags), 32'h0);
        check({tag, " pc"},    32'(dut.pc_q), 32'h0);
        check({tag, " acc"},   32'(dut.acc_q), 32'h0);
        check({tag, " mr"},    32'(dut.mr_q), 32'h0);
        check({tag, " ir"},    32'(dut.ir_q), 32'h0);
        check({tag, " state"}, 32'(dut.state_q), 32'h0);
    endtask

    initial begin
        steps[0] = '{"shiftr",  16'h09DD, 16'h0000, 4'b0000, 8'h11};
        steps[1] = '{"shiftl",  16'h13BA, 16'h0000, 4'b0000, 8'h13};
        steps[2] = '{"not1",    16'hEC45, 16'h0000, 4'b0001, 8'h15};
        steps[3] = '{"sub100",  16'hEBE1, 16'h0000, 4'b0001, 8'h17};
        steps[4] = '{"mpy",     16'hEB86, 16'h018C, 4'b0011, 8'h19};
        steps[5] = '{"add_ovf", 16'h8000, 16'h018C, 4'b0011, 8'h1C};
        steps[6] = '{"not2",    16'h7FFF, 16'h018C, 4'b0000, 8'h1E};

        // Reset asserted mid-run takes effect without a clock edge.
        cycles(3);
        rst = 1'b0;
        cycles(60);
        #2 rst = 1'b1;
        #1 check_reset_state("reset_async");
        $display("reset asserted mid-run: pc=0x%0h acc=0x%0h", dut.pc_q, dut.acc_q);
        cycles(5);
        check_reset_state("reset_hold");

        // Button already held at reset release must not skip the first HALT.
        btn = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(300);
        btn = 1'b0;
        // Glitches while running are ignored.
        repeat (20) begin
            cycles(13);
            #1 btn = 1'b1;
            #3 btn = 1'b0;
            cycles(3);
            #3 btn = 1'b1;
            #4 btn = 1'b0;
        end
        wait_halted("sum", 5000);
        check("sum pc",    32'(dut.pc_q), 32'h0F);
        check("sum acc",   32'(dut.acc_q), 32'h13BA);
        check("sum mr",    32'(dut.mr_q), 32'h0);
        check("sum flags", 32'(flags), 32'h0);
        $display("sum: pc=0x%0h acc=0x%0h flags=%b", dut.pc_q, dut.acc_q, flags);

        cycles(10000);
        check("idle state", 32'(dut.state_q), 32'd2);
        check("idle pc",    32'(dut.pc_q), 32'h0F);
        $display("idle 10000 cycles: state=%0d pc=0x%0h", dut.state_q, dut.pc_q);

        // One step per press, button held 150 cycles each time.
        for (int i = 0; i < 7; i++) begin
            press_hold(150);
            wait_halted(steps[i].name, 200);
            check({steps[i].name, " pc"},    32'(dut.pc_q),  32'(steps[i].pc));
            check({steps[i].name, " acc"},   32'(dut.acc_q), 32'(steps[i].acc));
            check({steps[i].name, " mr"},    32'(dut.mr_q),  32'(steps[i].mr));
            check({steps[i].name, " flags"}, 32'(flags),     32'(steps[i].flags));
            $display("step %s: pc=0x%0h acc=0x%0h mr=0x%0h flags=%b",
                     steps[i].name, dut.pc_q, dut.acc_q, dut.mr_q, flags);
        end

        // JMPGEZ 0 taken: the fetch after its EXEC starts at PC=0.
        btn = 1'b1;
        begin
            int k = 0;
            while (!(dut.state_q == 2'd1 && dut.ir_q == 16'h0500) && k < 60) begin
                @(negedge clk);
                k++;
            end
        end
        check("jmpgez ir", 32'(dut.ir_q), 32'h0500);
        @(negedge clk);
        check("jmpgez state", 32'(dut.state_q), 32'd0);
        check("jmpgez pc",    32'(dut.pc_q), 32'h00);
        $display("jmpgez: state=%0d pc=0x%0h", dut.state_q, dut.pc_q);
        cycles(140);
        btn = 1'b0;
        wait_halted("rerun", 5000);
        check("rerun pc",  32'(dut.pc_q), 32'h0F);
        check("rerun acc", 32'(dut.acc_q), 32'h13BA);
        check("rerun mr",  32'(dut.mr_q), 32'h018C);
        $display("rerun: pc=0x%0h acc=0x%0h", dut.pc_q, dut.acc_q);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
